// File: rtl/data_mem_handler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_handler_pkg
// Purpose  : Shared state encoding and constants for the data-memory handler.
// Revision : 1.0
// ============================================================================
package data_mem_handler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned WAIT_CNT_W             = 8;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Byte-lane enables, store-data replication and load extension.
// Revision : 1.0
// ============================================================================
module mem_lane_align (
  input  logic        is_byte,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  sel,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata_in[{lane, 3'b000} +: 8];
    if (is_byte) begin
      sel       = 4'b0001 << lane;
      wdata_out = {4{wdata_in[7:0]}};
      rdata_out = {{24{lane_byte[7]}}, lane_byte};
    end else begin
      sel       = 4'b1111;
      wdata_out = wdata_in;
      rdata_out = rdata_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_handler.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_handler
// Purpose  : Core load/store port to a request/ack bus with timeout abort.
// Revision : 1.0
// ============================================================================
module data_mem_handler
  import data_mem_handler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  // Timeout fires on the last waiting cycle, so the strobe is held exactly
  // TIMEOUT_CYCLES cycles when no ack ever arrives.
  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t            state_q,     state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic                  is_byte_q,   is_byte_d;
  logic [1:0]            lane_q,      lane_d;
  logic [31:0]           read_data_q, read_data_d;
  logic [31:0]           bus_addr_q,  bus_addr_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;
  logic [3:0]            bus_sel_q,   bus_sel_d;
  logic                  bus_read_q,  bus_read_d;
  logic                  bus_write_q, bus_write_d;
  logic                  bus_error_q, bus_error_d;

  logic        accepting;
  logic        req;
  logic        req_is_byte;
  logic        req_misaligned;
  logic        busy;
  logic        align_byte;
  logic [1:0]  align_lane;
  logic [3:0]  align_sel;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;

  assign accepting      = (state_q == IDLE) || (state_q == DONE);
  assign busy           = (state_q == READ) || (state_q == WRITE);
  assign req            = write_mem | read_mem;
  assign req_is_byte    = write_mem ? store_byte : load_byte;
  assign req_misaligned = accepting && req && !req_is_byte && (address[1:0] != 2'b00);

  // One aligner serves both directions: the incoming request while accepting,
  // the captured size/lane while a load is waiting for its data.
  assign align_byte = accepting ? req_is_byte  : is_byte_q;
  assign align_lane = accepting ? address[1:0] : lane_q;

  mem_lane_align u_lane_align (
    .is_byte   (align_byte),
    .lane      (align_lane),
    .wdata_in  (write_data),
    .rdata_in  (bus_rdata),
    .sel       (align_sel),
    .wdata_out (align_wdata),
    .rdata_out (align_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    is_byte_d   = is_byte_q;
    lane_d      = lane_q;
    read_data_d = read_data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    bus_read_d  = bus_read_q;
    bus_write_d = bus_write_q;
    bus_error_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (req_misaligned) begin
          if (!write_mem) begin
            read_data_d = '0;
          end
        end else if (req) begin
          state_d     = write_mem ? WRITE : READ;
          wait_cnt_d  = '0;
          is_byte_d   = req_is_byte;
          lane_d      = address[1:0];
          bus_addr_d  = {address[31:2], 2'b00};
          bus_wdata_d = align_wdata;
          bus_sel_d   = align_sel;
          bus_read_d  = !write_mem;
          bus_write_d = write_mem;
        end
      end

      READ, WRITE: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (bus_ack) begin
          if (state_q == READ) begin
            read_data_d = align_rdata;
          end
          state_d     = DONE;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
        end else if (wait_cnt_q == LAST_WAIT) begin
          if (state_q == READ) begin
            read_data_d = '0;
          end
          bus_error_d = 1'b1;
          state_d     = DONE;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      is_byte_q   <= 1'b0;
      lane_q      <= 2'b00;
      read_data_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      bus_read_q  <= 1'b0;
      bus_write_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      is_byte_q   <= is_byte_d;
      lane_q      <= lane_d;
      read_data_q <= read_data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      bus_read_q  <= bus_read_d;
      bus_write_q <= bus_write_d;
      bus_error_q <= bus_error_d;
    end
  end

  // The combinational handshake outputs are gated by reset so that every
  // output is low while nrst is asserted, even with a request pending.
  assign stall      = nrst & (busy | (accepting & req & ~req_misaligned));
  assign misaligned = nrst & req_misaligned;

  assign read_data = read_data_q;
  assign bus_error = bus_error_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;
  assign bus_read  = bus_read_q;
  assign bus_write = bus_write_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_handler
// Purpose  : Self-checking bench for data_mem_handler (TIMEOUT_CYCLES = 4).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_handler;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        read_mem = 1'b0, write_mem = 1'b0, load_byte = 1'b0, store_byte = 1'b0;
  logic [31:0] address = '0, write_data = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic        stall, misaligned, bus_error, bus_read, bus_write;
  logic [3:0]  bus_sel;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_rd = '0;

  int          ns, nb;
  logic [31:0] a0, w0;
  logic [3:0]  s0;
  logic        err;

  data_mem_handler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .load_byte  (load_byte),
    .store_byte (store_byte),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_sel    (bus_sel),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic byt, input logic [31:0] addr,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    if (!byt) return rd;
    sh = rd >> (32'(addr[1:0]) * 8);
    return sh[7] ? {24'hFFFFFF, sh[7:0]} : {24'h000000, sh[7:0]};
  endfunction

  // Issues one access at the current negedge, answers with bus_ack on bus
  // cycle ack_on (0 = never) and returns at the negedge of the DONE cycle.
  task automatic run_access(input string tag, input logic wr, input logic byt,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ack_on,
                            output int n_stall, output int n_strobe,
                            output logic [31:0] fa, output logic [3:0] fs,
                            output logic [31:0] fw, output logic ferr);
    logic [31:0] e;
    logic        done;
    done = 1'b0; n_stall = 0; n_strobe = 0; fa = '0; fs = '0; fw = '0; ferr = 1'b0;
    if (wr)                           e = model_rd;
    else if (ack_on == 0 || ack_on > int'(TO)) e = '0;
    else                              e = exp_load(byt, addr, rdata);
    model_rd = e;
    sb_q.push_back(e);
    write_mem = wr; read_mem = !wr; load_byte = byt; store_byte = byt;
    address = addr; write_data = wd; bus_rdata = rdata;
    #1;
    if (stall) n_stall++;
    @(negedge clk);
    write_mem = 1'b0; read_mem = 1'b0; address = ~addr; write_data = ~wd;
    for (int c = 1; c <= 40; c++) begin
      if (stall) n_stall++;
      if (bus_read || bus_write) begin
        n_strobe++;
        if (c == 1) begin fa = bus_addr; fs = bus_sel; fw = bus_wdata; end
      end
      if (!stall) begin done = 1'b1; ferr = bus_error; break; end
      bus_ack = (c == ack_on);
      @(negedge clk);
      bus_ack = 1'b0;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else                  check({tag, "_rd"}, read_data, sb_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    // Reset state, with a request pending to prove stall is held low.
    read_mem = 1'b1; address = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",      {31'b0, stall},      32'd0);
    check("rst_read_data",  read_data,           32'd0);
    check("rst_bus_read",   {31'b0, bus_read},   32'd0);
    check("rst_bus_write",  {31'b0, bus_write},  32'd0);
    check("rst_bus_sel",    {28'b0, bus_sel},    32'd0);
    check("rst_bus_addr",   bus_addr,            32'd0);
    check("rst_bus_error",  {31'b0, bus_error},  32'd0);
    check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    read_mem = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Word load, ack on third bus cycle.
    run_access("wload", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, ns, nb, a0, s0, w0, err);
    check("wload_stall",  32'(ns), 32'd4);
    check("wload_strobe", 32'(nb), 32'd3);
    check("wload_addr",   a0, 32'h100);
    check("wload_sel",    {28'b0, s0}, 32'hF);
    check("wload_err",    {31'b0, err}, 32'd0);
    @(negedge clk);

    // Ack while idle must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack_rd",    read_data, 32'hDEADBEEF);
    check("idle_ack_strb",  {30'b0, bus_read, bus_write}, 32'd0);
    check("idle_ack_stall", {31'b0, stall}, 32'd0);

    // Byte store to lane 3.
    run_access("bstore", 1'b1, 1'b1, 32'h203, 32'h000000A5, 32'h0, 1, ns, nb, a0, s0, w0, err);
    check("bstore_sel",   {28'b0, s0}, 32'h8);
    check("bstore_wdata", w0, 32'hA5A5A5A5);
    check("bstore_addr",  a0, 32'h200);
    check("bstore_stall", 32'(ns), 32'd2);
    @(negedge clk);

    // Byte load, negative byte in lane 2.
    run_access("bload", 1'b0, 1'b1, 32'h302, 32'h0, 32'h00800000, 2, ns, nb, a0, s0, w0, err);
    check("bload_sel",   {28'b0, s0}, 32'h4);
    check("bload_addr",  a0, 32'h300);
    check("bload_stall", 32'(ns), 32'd3);

    // Back-to-back request issued in the DONE cycle, positive byte in lane 3.
    run_access("bload3", 1'b0, 1'b1, 32'h307, 32'h0, 32'h7F000000, 1, ns, nb, a0, s0, w0, err);
    check("bload3_stall", 32'(ns), 32'd2);
    check("bload3_sel",   {28'b0, s0}, 32'h8);
    @(negedge clk);

    // Word store, read_data must be preserved.
    run_access("wstore", 1'b1, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0, 2, ns, nb, a0, s0, w0, err);
    check("wstore_wdata", w0, 32'hCAFEF00D);
    check("wstore_sel",   {28'b0, s0}, 32'hF);
    @(negedge clk);

    // Misaligned word store.
    write_mem = 1'b1; store_byte = 1'b0; address = 32'h401; write_data = 32'h11223344;
    #1;
    check("mis_st_pulse", {31'b0, misaligned}, 32'd1);
    check("mis_st_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    write_mem = 1'b0;
    #1;
    check("mis_st_wr",    {31'b0, bus_write}, 32'd0);
    check("mis_st_end",   {31'b0, misaligned}, 32'd0);
    check("mis_st_rd",    read_data, model_rd);

    // Misaligned word load clears read_data.
    read_mem = 1'b1; load_byte = 1'b0; address = 32'h102;
    #1;
    check("mis_ld_pulse", {31'b0, misaligned}, 32'd1);
    check("mis_ld_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    read_mem = 1'b0;
    model_rd = '0;
    check("mis_ld_rd",    read_data, model_rd);
    check("mis_ld_strb",  {31'b0, bus_read}, 32'd0);

    // Timeout with no ack, preceded by a load so read_data is non-zero.
    run_access("pre", 1'b0, 1'b0, 32'h600, 32'h0, 32'h55AA55AA, 1, ns, nb, a0, s0, w0, err);
    @(negedge clk);
    run_access("tmo", 1'b0, 1'b0, 32'h604, 32'h0, 32'h11111111, 0, ns, nb, a0, s0, w0, err);
    check("tmo_strobe", 32'(nb), TO);
    check("tmo_err",    {31'b0, err}, 32'd1);
    check("tmo_stall",  32'(ns), TO + 1);
    @(negedge clk);
    check("tmo_err_end", {31'b0, bus_error}, 32'd0);

    // Ack on the very cycle the timeout would fire wins.
    run_access("tmo_ack", 1'b0, 1'b0, 32'h608, 32'h0, 32'h22222222, int'(TO), ns, nb, a0, s0, w0, err);
    check("tmo_ack_err",    {31'b0, err}, 32'd0);
    check("tmo_ack_strobe", 32'(nb), TO);
    @(negedge clk);

    // Asynchronous reset in the middle of a write.
    write_mem = 1'b1; store_byte = 1'b0; address = 32'h500; write_data = 32'h12345678;
    @(negedge clk);
    write_mem = 1'b0;
    check("rstw_pre_wr", {31'b0, bus_write}, 32'd1);
    nrst = 1'b0;
    #1;
    check("rstw_wr",    {31'b0, bus_write}, 32'd0);
    check("rstw_stall", {31'b0, stall}, 32'd0);
    check("rstw_addr",  bus_addr, 32'd0);
    check("rstw_sel",   {28'b0, bus_sel}, 32'd0);
    check("rstw_wdata", bus_wdata, 32'd0);
    check("rstw_rd",    read_data, 32'd0);
    model_rd = '0;
    sb_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // First request after reset: no extra latency.
    run_access("post_rst", 1'b0, 1'b0, 32'h700, 32'h0, 32'h0BADCAFE, 1, ns, nb, a0, s0, w0, err);
    check("post_rst_stall",  32'(ns), 32'd2);
    check("post_rst_strobe", 32'(nb), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_handler.md
DATA_MEM_HANDLER -- requirements
Module: data_mem_handler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles to wait for bus_ack before abort; legal range 1..255.
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port nrst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have these core-side inputs:
- read_mem  in  1  load request
- write_mem  in  1  store request
- load_byte  in  1  load is a byte, else a word
- store_byte  in  1  store is a byte, else a word
- address  in  32  byte address
- write_data  in  32  store data; byte stores use [7:0]
REQ-005 SHALL have these core-side outputs:
- read_data  out  32  load result
- stall  out  1  core must hold the current instruction
- misaligned  out  1  one-cycle pulse on a word access with address[1:0] != 0
- bus_error  out  1  one-cycle pulse on timeout
REQ-006 SHALL have these bus-side ports:
- bus_addr  out  32  word-aligned address ({address[31:2],2'b00})
- bus_wdata  out  32  write data
- bus_sel  out  4  byte-lane enables
- bus_read  out  1  read strobe
- bus_write  out  1  write strobe
- bus_rdata  in  32  read data
- bus_ack  in  1  completion

Function
REQ-007 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-008 IDLE or DONE with a request SHALL drive stall=1 combinationally in that cycle, register address, size and data, and go to WRITE (write_mem) or READ (read_mem) next cycle.
REQ-009 write_mem and read_mem both high SHALL be treated as a write.
REQ-010 IDLE or DONE with no request SHALL go to IDLE.
REQ-011 READ/WRITE SHALL hold bus_read/bus_write=1, stall=1 and stable bus_addr/bus_wdata/bus_sel until bus_ack or timeout.
REQ-012 bus_ack in READ SHALL capture the extended data into read_data, then go to DONE.
REQ-013 bus_ack in WRITE SHALL go to DONE; read_data is unchanged.
REQ-014 In DONE, stall SHALL be 0 unless a new request is present (REQ-008); read_data stays valid through DONE.
REQ-015 Word access: bus_sel=4'b1111, bus_wdata=write_data; read_data=bus_rdata.
REQ-016 Byte access: bus_sel=4'b0001<<address[1:0]; bus_wdata={4{write_data[7:0]}}; read_data=sign-extended lane address[1:0] of bus_rdata.
REQ-017 A word access with address[1:0]!=0 SHALL not start a bus cycle, SHALL pulse misaligned for one cycle with stall=0, SHALL set read_data=0 for loads, and SHALL leave the state IDLE.
REQ-018 An 8-bit wait counter SHALL clear on entering READ/WRITE and increment each cycle without bus_ack.
REQ-019 When the counter reaches TIMEOUT_CYCLES, the block SHALL drop the strobes, pulse bus_error for one cycle, set read_data=0 for a read, and go to DONE.
REQ-020 bus_ack in the same cycle as the timeout SHALL win (normal completion, no bus_error).
REQ-021 bus_ack outside READ/WRITE SHALL be ignored.

Reset
REQ-022 nrst low SHALL immediately force state IDLE, counter 0, and all outputs 0, including the bus strobes mid-transaction.
REQ-023 After reset release, the first request SHALL be handled per REQ-008 with no extra latency.

Structure
REQ-024 A shared package SHALL hold the mem_state_t enum (IDLE, READ, WRITE, DONE) and the TIMEOUT_CYCLES default constant.
REQ-025 Lane select, replication and sign extension SHALL live in a combinational sub-module mem_lane_align.

Verification
REQ-026 The bench SHALL cover word load at 0x100, bus_ack on the 3rd bus cycle with bus_rdata=0xDEADBEEF -> stall high 4 cycles, read_data=0xDEADBEEF in DONE.
REQ-027 The bench SHALL cover byte store at 0x203 with write_data=0x000000A5 -> bus_sel=4'b1000, bus_wdata=0xA5A5A5A5, bus_addr=0x200.
REQ-028 The bench SHALL cover byte load at 0x302 with bus_rdata=0x00800000 -> read_data=0xFFFFFF80.
REQ-029 The bench SHALL cover a word store at 0x401 -> misaligned pulse, no bus_write, stall=0.
REQ-030 The bench SHALL cover a read with no bus_ack and TIMEOUT_CYCLES=4 -> strobe held 4 cycles, bus_error pulse, read_data=0, then a DONE cycle.
REQ-031 The bench SHALL cover nrst low during WRITE -> bus_write=0 immediately, state IDLE, outputs 0.
